// File: rtl/peak_tx_sched_if.sv
// rtl/peak_tx_sched_if.sv - byte launch handshake between frame scheduler and UART TX
interface peak_tx_sched_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/peak_tx_sched.sv
// rtl/peak_tx_sched.sv - periodic/forced peak snapshot framer feeding one UART TX
// Optional sixth checksum byte enabled by defining PEAK_TX_CHKSUM_EN.
module peak_tx_sched #(
  parameter int unsigned FRAME_PERIOD = 1000000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       max_1,
  input  logic [7:0]       max_2,
  input  logic [7:0]       max_3,
  input  logic [7:0]       max_4,
  input  logic             force_frame,
  peak_tx_sched_if.master  tx,
  output logic             peak_clr,
  output logic             frame_busy,
  output logic             overrun
);

  localparam int CNT_W = $clog2(FRAME_PERIOD);
`ifdef PEAK_TX_CHKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic [2:0] {IDLE, LATCH, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] period_cnt;
  logic             tick, request, pending, launch;
  logic [7:0]       shadow_1, shadow_2, shadow_3, shadow_4;
  logic [7:0]       tx_data_q, frame_byte;
  logic [2:0]       byte_idx;
  logic [1:0]       ack_cnt;

  assign tick    = (period_cnt == CNT_W'(FRAME_PERIOD - 1));
  assign request = tick | force_frame;

  always_ff @(posedge clock) begin
    if (!reset)    period_cnt <= '0;
    else if (tick) period_cnt <= '0;
    else           period_cnt <= period_cnt + CNT_W'(1);
  end

  // A request landing in the LATCH cycle simply re-queues; it is not an overrun.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (state == LATCH) begin
      pending <= request;
    end else if (request) begin
      if (pending) overrun <= 1'b1;
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow_1  <= '0;
      shadow_2  <= '0;
      shadow_3  <= '0;
      shadow_4  <= '0;
      tx_data_q <= '0;
      byte_idx  <= '0;
      ack_cnt   <= '0;
    end else begin
      if (state == LATCH) begin
        shadow_1 <= max_1;
        shadow_2 <= max_2;
        shadow_3 <= max_3;
        shadow_4 <= max_4;
        byte_idx <= '0;
      end
      if (launch) tx_data_q <= frame_byte;
      if (state == WAIT_ACK) ack_cnt <= ack_cnt + 2'd1;
      else                   ack_cnt <= '0;
      if (state == WAIT_DONE && !tx.tx_busy) byte_idx <= byte_idx + 3'd1;
    end
  end

`ifdef PEAK_TX_CHKSUM_EN
  logic [7:0] checksum;
  assign checksum = shadow_1 + shadow_2 + shadow_3 + shadow_4;
`endif

  always_comb begin
    frame_byte = 8'h00;
    case (byte_idx)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = shadow_1;
      3'd2:    frame_byte = shadow_2;
      3'd3:    frame_byte = shadow_3;
      3'd4:    frame_byte = shadow_4;
`ifdef PEAK_TX_CHKSUM_EN
      3'd5:    frame_byte = checksum;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  // WAIT_ACK gives up after four quiet cycles so a TX with no visible busy still advances.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    peak_clr  = 1'b0;
    case (state)
      IDLE:      if (pending) state_nxt = LATCH;
      LATCH: begin
        peak_clr  = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (!tx.tx_busy) begin
          launch    = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK:  if (tx.tx_busy || ack_cnt == 2'd3) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx.tx_busy) state_nxt = (byte_idx == LAST_IDX) ? IDLE : SEND;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  assign tx.tx_start = launch;
  assign tx.tx_data  = launch ? frame_byte : tx_data_q;
  assign frame_busy  = (state != IDLE);

endmodule

// File: tb/tb_peak_tx_sched.sv
// tb/tb_peak_tx_sched.sv - directed vector bench for peak_tx_sched
module tb_peak_tx_sched;

`ifdef PEAK_TX_CHKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  typedef struct {
    logic [7:0] m1, m2, m3, m4;
    int         busy_len;
    logic [7:0] ck;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] max_1 = '0, max_2 = '0, max_3 = '0, max_4 = '0;
  logic       force_frame = 1'b0;
  logic       peak_clr, frame_busy, overrun;

  peak_tx_sched_if tx_if();

  peak_tx_sched #(.FRAME_PERIOD(100), .SYNC_BYTE(8'hA5)) dut (
    .clock       (clock),
    .reset       (reset),
    .max_1       (max_1),
    .max_2       (max_2),
    .max_3       (max_3),
    .max_4       (max_4),
    .force_frame (force_frame),
    .tx          (tx_if),
    .peak_clr    (peak_clr),
    .frame_busy  (frame_busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int         cyc = 0;
  int         n_checks = 0, n_fail = 0;
  int         busy_len = 0, busy_left = 0, viol = 0, since_clr = 0;
  bit         arm = 0, prev_start = 0, clr_armed = 0;
  logic [7:0] bytes[$];
  int         starts[$];
  int         clr_cycles[$];

  initial tx_if.tx_busy = 1'b0;

  always @(posedge clock) cyc++;

  // UART model plus monitor: busy rises the cycle after a launch and stays up busy_len cycles.
  always @(negedge clock) begin
    if (!reset) begin
      tx_if.tx_busy = 1'b0; busy_left = 0; arm = 0; clr_armed = 0;
    end else if (arm) begin
      arm = 0;
      if (busy_len > 0) begin tx_if.tx_busy = 1'b1; busy_left = busy_len; end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_if.tx_busy = 1'b0;
    end
    #1;
    if (tx_if.tx_start) begin
      bytes.push_back(tx_if.tx_data);
      starts.push_back(cyc);
      arm = 1;
      since_clr++;
      if (tx_if.tx_busy || prev_start) viol++;
    end
    prev_start = tx_if.tx_start;
    if (peak_clr) begin
      if (clr_armed && since_clr != NB) viol++;
      clr_armed = 1; since_clr = 0;
      clr_cycles.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask

  task automatic do_reset(output int r);
    reset = 1'b0; force_frame = 1'b0;
    cyc_wait(3);
    bytes.delete(); starts.delete(); clr_cycles.delete();
    reset = 1'b1;
    r = cyc;
  endtask

  task automatic pulse_force(output int t);
    t = cyc;
    force_frame = 1'b1;
    cyc_wait(1);
    force_frame = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k = 0;
    while ((bytes.size() < n || frame_busy) && k < budget) begin cyc_wait(1); k++; end
    check({name, "_done"}, k < budget, 1);
  endtask

  function automatic logic [63:0] got_byte(input int i);
    return (i < bytes.size()) ? {56'h0, bytes[i]} : 64'hDEAD;
  endfunction

  task automatic check_frame(input string name, input int base, input vec_t v);
    logic [7:0] exp[6];
    exp[0] = 8'hA5; exp[1] = v.m1; exp[2] = v.m2; exp[3] = v.m3; exp[4] = v.m4; exp[5] = v.ck;
    for (int i = 0; i < NB; i++)
      check($sformatf("%s_byte%0d", name, i), got_byte(base + i), {56'h0, exp[i]});
  endtask

  task automatic set_max(input vec_t v);
    max_1 = v.m1; max_2 = v.m2; max_3 = v.m3; max_4 = v.m4;
  endtask

  vec_t vecs[5];
  vec_t base_v;

  initial begin
    int r, t, n_before, k;
    vecs[0] = '{8'h10, 8'h20, 8'h30, 8'h40, 10, 8'hA0};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 0,  8'hFC};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1,  8'h00};
    vecs[3] = '{8'h01, 8'h80, 8'h7F, 8'h02, 3,  8'h02};
    vecs[4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 0,  8'hFE};
    base_v  = vecs[0];

    cyc_wait(2);
    check("rst_tx_start", tx_if.tx_start, 0);
    check("rst_tx_data", tx_if.tx_data, 0);
    check("rst_peak_clr", peak_clr, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_overrun", overrun, 0);

    for (int i = 0; i < 5; i++) begin
      do_reset(r);
      set_max(vecs[i]);
      busy_len = vecs[i].busy_len;
      cyc_wait(2);
      pulse_force(t);
      wait_bytes(NB, 400, $sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), 0, vecs[i]);
      check($sformatf("vec%0d_clr_count", i), clr_cycles.size(), 1);
      check($sformatf("vec%0d_clr_cycle", i), clr_cycles.size() > 0 ? clr_cycles[0] : -1, t + 2);
      check($sformatf("vec%0d_first_start", i), starts.size() > 0 && starts[0] >= t + 3, 1);
      check($sformatf("vec%0d_overrun", i), overrun, 0);
      if (vecs[i].busy_len == 0)
        for (int b = 1; b < NB; b++)
          check($sformatf("vec%0d_timeout_gap%0d", i, b),
                b < starts.size() ? starts[b] - starts[b-1] : -1, 6);
    end

    // periodic frames, FRAME_PERIOD = 100
    do_reset(r);
    set_max(base_v); busy_len = 10;
    cyc_wait(290);
    check("per_clr_count", clr_cycles.size(), 2);
    check("per_clr0", clr_cycles.size() > 0 ? clr_cycles[0] : -1, r + 101);
    check("per_clr1", clr_cycles.size() > 1 ? clr_cycles[1] : -1, r + 201);
    check("per_nbytes", bytes.size(), 2 * NB);
    check_frame("per_f0", 0, base_v);
    check_frame("per_f1", NB, base_v);
    check("per_overrun", overrun, 0);

    // snapshot isolation
    do_reset(r);
    set_max(base_v); busy_len = 10;
    cyc_wait(2);
    pulse_force(t);
    k = 0;
    while (clr_cycles.size() == 0 && k < 20) begin cyc_wait(1); k++; end
    check("snap_clr_seen", k < 20, 1);
    cyc_wait(1);
    max_1 = 8'hFF;
    wait_bytes(NB, 400, "snap");
    check_frame("snap", 0, base_v);
    max_1 = base_v.m1;

    // force in the tick cycle
    do_reset(r);
    busy_len = 10;
    cyc_wait(99);
    pulse_force(t);
    cyc_wait(79);
    check("coll_clr_count", clr_cycles.size(), 1);
    check("coll_clr_cycle", clr_cycles.size() > 0 ? clr_cycles[0] : -1, r + 101);
    check("coll_overrun", overrun, 0);
    check_frame("coll", 0, base_v);

    // overrun with a slow transmitter
    do_reset(r);
    busy_len = 50;
    cyc_wait(250);
    check("ovr_frame1_busy", frame_busy, 1);
    check("ovr_after_2nd_tick", overrun, 0);
    cyc_wait(55);
    check("ovr_after_3rd_tick", overrun, 1);
    k = 0;
    while (clr_cycles.size() < 3 && k < 1000) begin cyc_wait(1); k++; end
    check("ovr_third_frame_started", k < 1000, 1);
    check_frame("ovr_f0", 0, base_v);
    check_frame("ovr_f1", NB, base_v);
    check("ovr_f0_before_clr1", starts.size() >= NB && clr_cycles.size() > 1 && starts[NB-1] < clr_cycles[1], 1);
    check("ovr_f1_after_clr1", starts.size() > NB && clr_cycles.size() > 1 && starts[NB] > clr_cycles[1], 1);

    // reset in the middle of byte 3
    do_reset(r);
    busy_len = 10;
    cyc_wait(2);
    pulse_force(t);
    k = 0;
    while (bytes.size() < 3 && k < 200) begin cyc_wait(1); k++; end
    check("mid_reached_byte3", k < 200, 1);
    cyc_wait(2);
    reset = 1'b0;
    n_before = bytes.size();
    cyc_wait(1);
    check("mid_tx_start", tx_if.tx_start, 0);
    check("mid_tx_data", tx_if.tx_data, 0);
    check("mid_peak_clr", peak_clr, 0);
    check("mid_frame_busy", frame_busy, 0);
    check("mid_overrun", overrun, 0);
    cyc_wait(3);
    check("mid_no_start_in_reset", bytes.size(), n_before);
    do_reset(r);
    cyc_wait(2);
    pulse_force(t);
    wait_bytes(NB, 400, "mid_restart");
    check_frame("mid_restart", 0, base_v);
    check("mid_restart_clr_count", clr_cycles.size(), 1);

    check("handshake_and_frame_invariants", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peak_tx_sched.md
# peak_tx_sched

Frame scheduler that shares one UART transmitter among the four peak-hold channels of the ADC acquisition path. Every FRAME_PERIOD clocks (or on demand), it snapshots the four channel maxima, pulses a clear to the peak-hold registers, and serializes a framed packet byte by byte through a start/busy handshake to the UART TX. It sits between the peak-hold outputs and the UART transmitter.

## Interface
- FRAME_PERIOD, 1000000: clocks between automatic frame requests; must be ≥ 16.
- SYNC_BYTE, 8'hA5: first byte of every frame.

- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- max_1..max_4  in  8 each  channel peak-hold values.
- force  in  1  level-sampled request for an immediate frame.
- tx_busy  in  1  UART TX busy; high while a byte is shifting out.
- tx_start  out  1  one-cycle byte-launch strobe.
- tx_data  out  8  byte to send; valid while tx_start is high and held until the next launch.
- peak_clr  out  1  one-cycle pulse that clears the external peak-hold registers.
- frame_busy  out  1  high from LATCH through the final byte's completion.
- overrun  out  1  sticky flag; a request arrived while one was already pending.

## Operation
- Period counter: counts 0..FRAME_PERIOD-1 and wraps. A tick occurs in the cycle the counter equals FRAME_PERIOD-1. It runs continuously, independent of the FSM.
- Request: tick OR force sets `pending`.
  - If `pending` is already set and not being consumed that cycle, the request sets `overrun`.
  - `overrun` clears only on reset.
  - At most one request is ever queued.
- FSM states and transitions:
  - IDLE: moves to LATCH when `pending` is set.
  - LATCH (one cycle): copies max_1..4 into shadow registers, asserts peak_clr, clears `pending`, sets byte index to 0.
  - SEND: when tx_busy is low, asserts tx_start and drives tx_data = frame[index]; then moves to WAIT_ACK. While tx_busy is high, it holds.
  - WAIT_ACK: waits for tx_busy high. If tx_busy stays low for 4 cycles, the byte is treated as accepted (covers transmitters with no visible busy on short bytes). Then moves to WAIT_DONE.
  - WAIT_DONE: waits for tx_busy low. Then increments index; it moves to SEND if bytes remain, otherwise to IDLE.
- Frame byte order: SYNC_BYTE, then the ch1..ch4 snapshots, then the optional checksum (see Configuration).
- Snapshot isolation: the channel inputs may change during a frame without affecting the bytes sent.
- Simultaneous events:
  - Tick and force in the same cycle count as one request.
  - A request arriving in the same cycle LATCH consumes `pending` re-sets `pending` without setting `overrun`.
- Reset mid-frame: the frame is abandoned, with no further tx_start.

## Timing
- Reset values: all outputs 0, counter 0, `pending` 0, state IDLE, shadows 0.
- Request at cycle T (tick or force sampled): `pending` is set at T+1, LATCH/peak_clr occurs at T+2, and the first tx_start is no earlier than T+3.
- tx_start is never high for two consecutive cycles and never high while tx_busy is high.
- frame_busy rises with LATCH and falls on the cycle after the last byte's tx_busy falls.

## Configuration
- PEAK_TX_CHKSUM_EN defined: a sixth byte is appended, equal to (ch1+ch2+ch3+ch4) mod 256 over the snapshot values. The frame is 6 bytes.
- PEAK_TX_CHKSUM_EN undefined: the frame is 5 bytes and there is no checksum logic.

## Test plan
- Periodic frame: FRAME_PERIOD=100, max=8'h10/20/30/40, TX model with busy 10 cycles. Required: bytes A5,10,20,30,40 (+A0 with CHKSUM_EN). One peak_clr pulse per frame. Frames start every 100 cycles.
- Snapshot: change max_1 to 8'hFF one cycle after peak_clr. Required: the frame still sends 8'h10.
- Overrun: TX busy 50 cycles per byte with FRAME_PERIOD=100. Required: the second tick queues, the third tick sets overrun=1, and frames are never interleaved or truncated.
- Force/tick collision: force high in the tick cycle. Required: exactly one frame and overrun=0.
- No-busy TX: tx_busy tied low. Required: each byte advances after the 4-cycle WAIT_ACK timeout, and the full frame is emitted.
- Reset mid-frame: reset low during byte 3. Required: the next cycle shows all outputs 0 and state IDLE; after release, the next frame starts cleanly with SYNC_BYTE.
